multi_lane_fetch_unit: RTL

- Parametrised instruction-fetch front end for the multi-lane processor core.
- Holds one program counter per lane and issues synchronous instruction-memory reads (1-cycle latency).
- Buffers returned instructions in a per-lane FIFO with a valid/ready handshake toward decode.
- Applies branch redirects with flush of stale fetches; supports unified mode (lane 0 only, XLEN-bit PC) and split mode (all lanes, 32-bit PCs).

---
 rtl/multi_lane_fetch_unit.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/multi_lane_fetch_unit.sv
// multi_lane_fetch_unit: per-lane PC, 1-cycle imem read issue, per-lane
// instruction FIFO toward decode, branch redirect with epoch-based flush of
// stale fetches, unified (lane 0, XLEN PC) / split (all lanes, 32-bit PC) mode.
// Optional: FETCH_PERF_CNT_EN adds saturating per-lane fetch/flush counters.

module mlfu_lane #(
   parameter int              XLEN      = 64,
   parameter int              ADDR_W    = 32,
   parameter int              BUF_DEPTH = 2,
   parameter logic [XLEN-1:0] BASE_PC   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              active,
   input  logic              split,
   input  logic              mode_chg,
   input  logic              fetch_en,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [XLEN-1:0]   out_pc,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_imm,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushes
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = CW + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_ent_t;

   function automatic logic [XLEN-1:0] zx32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = '0;
      r[31:0] = v;
      return r;
   endfunction

   logic [XLEN-1:0] pc_q, pc_d, issue_pc_q, issue_pc_d, target;
   logic            inflight_q, inflight_d, tag_q, tag_d, epoch_q, epoch_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [OW-1:0]   occ;
   fetch_ent_t      fifo_q [BUF_DEPTH];
   fetch_ent_t      fifo_d [BUF_DEPTH];
   fetch_ent_t      head;
   logic            pop, redir, flush, push;
   logic signed [XLEN-1:0] imm_sh;
   logic signed [31:0]     imm_sh32;
   logic [31:0]            tgt32, inc32;

   assign head      = fifo_q[rd_ptr_q];
   assign out_valid = active & (cnt_q != '0);
   assign out_instr = out_valid ? head.instr : '0;
   assign out_pc    = out_valid ? head.pc : '0;

   // Handshake, redirect/flush decode, issue decision and next-state.
   always_comb begin
      pop   = out_valid & out_ready;
      // A pending mode change overrides any redirect on the same cycle.
      redir = pop & redirect_valid & ~mode_chg;
      flush = redir | mode_chg;
      // Responses tagged with an old epoch belong to a flushed stream.
      push  = inflight_q & (tag_q == epoch_q) & ~flush;
      // Counting the pop lets a full FIFO refill in the same cycle it drains.
      occ   = OW'(cnt_q) + OW'(inflight_q) - OW'(pop);
      imem_req  = rst_n & active & fetch_en & ~flush & (occ < OW'(BUF_DEPTH));
      imem_addr = imem_req ? pc_q[ADDR_W-1:0] : '0;

      imm_sh   = $signed(redirect_imm) >>> 2;
      imm_sh32 = $signed(redirect_imm[31:0]) >>> 2;
      tgt32    = head.pc[31:0] + $unsigned(imm_sh32);
      inc32    = pc_q[31:0] + 32'd1;
      target   = split ? zx32(tgt32) : head.pc + $unsigned(imm_sh);

      pc_d = pc_q;
      if (mode_chg)      pc_d = BASE_PC;
      else if (redir)    pc_d = target;
      else if (imem_req) pc_d = split ? zx32(inc32) : pc_q + XLEN'(1);

      epoch_d    = epoch_q ^ flush;
      inflight_d = imem_req;
      tag_d      = imem_req ? epoch_q : tag_q;
      issue_pc_d = imem_req ? pc_q : issue_pc_q;

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            fifo_d[wr_ptr_q] = '{pc: issue_pc_q, instr: imem_rdata};
            wr_ptr_d         = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Lane state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= BASE_PC;
         issue_pc_q <= '0;
         inflight_q <= 1'b0;
         tag_q      <= 1'b0;
         epoch_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         for (int k = 0; k < BUF_DEPTH; k++) fifo_q[k] <= '0;
      end else begin
         pc_q       <= pc_d;
         issue_pc_q <= issue_pc_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         epoch_q    <= epoch_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         fifo_q     <= fifo_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetched_q, fetched_d, flushes_q, flushes_d;

   // Saturating push and flush counters.
   always_comb begin
      fetched_d = fetched_q;
      flushes_d = flushes_q;
      if (push  && fetched_q != '1) fetched_d = fetched_q + 32'd1;
      if (flush && flushes_q != '1) flushes_d = flushes_q + 32'd1;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q <= '0;
         flushes_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         flushes_q <= flushes_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_flushes = flushes_q;
`else
   assign perf_fetched = '0;
   assign perf_flushes = '0;
`endif

endmodule

module multi_lane_fetch_unit #(
   parameter int XLEN        = 64,
   parameter int NUM_LANES   = 2,
   parameter int ADDR_W      = 32,
   parameter int LANE_STRIDE = 512,
   parameter int BUF_DEPTH   = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               mode,
   input  logic [NUM_LANES-1:0]               fetch_en,
   output logic [NUM_LANES-1:0]               imem_req,
   output logic [NUM_LANES-1:0][ADDR_W-1:0]   imem_addr,
   input  logic [NUM_LANES-1:0][31:0]         imem_rdata,
   output logic [NUM_LANES-1:0]               out_valid,
   input  logic [NUM_LANES-1:0]               out_ready,
   output logic [NUM_LANES-1:0][31:0]         out_instr,
   output logic [NUM_LANES-1:0][XLEN-1:0]     out_pc,
   input  logic [NUM_LANES-1:0]               redirect_valid,
   input  logic [NUM_LANES-1:0][XLEN-1:0]     redirect_imm,
   output logic [NUM_LANES-1:0][31:0]         perf_fetched,
   output logic [NUM_LANES-1:0][31:0]         perf_flushes
);
   logic mode_q, mode_d, mode_chg;
   logic [NUM_LANES-1:0] lane_active;

   // A mode flip is seen combinationally and committed on the next edge.
   always_comb begin
      mode_d   = mode;
      mode_chg = mode ^ mode_q;
   end

   // Mode register; reset captures the current mode so no flush follows reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mode_q <= mode;
      else        mode_q <= mode_d;
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_active[i] = (i == 0) ? 1'b1 : ~mode_q;

      mlfu_lane #(
         .XLEN      (XLEN),
         .ADDR_W    (ADDR_W),
         .BUF_DEPTH (BUF_DEPTH),
         .BASE_PC   (XLEN'(64'(i) * 64'(LANE_STRIDE)))
      ) u_lane (
         .clk            (clk),
         .rst_n          (rst_n),
         .active         (lane_active[i]),
         .split          (~mode_q),
         .mode_chg       (mode_chg),
         .fetch_en       (fetch_en[i]),
         .imem_req       (imem_req[i]),
         .imem_addr      (imem_addr[i]),
         .imem_rdata     (imem_rdata[i]),
         .out_valid      (out_valid[i]),
         .out_ready      (out_ready[i]),
         .out_instr      (out_instr[i]),
         .out_pc         (out_pc[i]),
         .redirect_valid (redirect_valid[i]),
         .redirect_imm   (redirect_imm[i]),
         .perf_fetched   (perf_fetched[i]),
         .perf_flushes   (perf_flushes[i])
      );
   end

endmodule
